// File: rtl/tick_period_meter.sv
// tick_period_meter
//   Measures the number of clk cycles between rising edges of an asynchronous
//   strobe and reports the divider value (N-1) that reproduces that rate on a
//   tick clock divider. Used in front of the bus receive logic to recover the
//   peer's bit-timing rate.
//
//   Parameters:
//     WIDTH        width of divider_out; measurable interval N = 2 .. 2**WIDTH
//   Ports:
//     clk          system clock
//     rst_n        asynchronous active-low reset
//     enable       1 = measure, 0 = hold in IDLE
//     clear        synchronous pulse, clears the sticky overflow flag
//     sig_in       asynchronous strobe, rate taken from its rising edges
//     edge_tick    one-cycle pulse per detected rising edge
//     divider_out  last measured divider value (N-1)
//     valid        one-cycle pulse when divider_out updates
//     locked       at least one good measurement since last ARM entry
//     overflow     sticky: an interval exceeded 2**WIDTH cycles
//   Build option:
//     TICK_PERIOD_AVERAGING_EN  average 4 consecutive intervals per update
module tick_period_meter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             clear,
   input  logic             sig_in,
   output logic             edge_tick,
   output logic [WIDTH-1:0] divider_out,
   output logic             valid,
   output logic             locked,
   output logic             overflow
);

   typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

   // First count value that can no longer be a legal interval (2**WIDTH + 1)
   localparam logic [WIDTH:0] CNT_LIMIT = {1'b1, {(WIDTH-1){1'b0}}, 1'b1};

   state_t         state;
   state_t         state_next;
   logic           s1;
   logic           s2;
   logic           s3;
   logic [WIDTH:0] cnt;
   logic           ovf_hit;
   logic           take;

   // Two-flop synchronizer plus one delay flop for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         s3        <= 1'b0;
         edge_tick <= 1'b0;
      end else begin
         s1        <= sig_in;
         s2        <= s1;
         s3        <= s2;
         edge_tick <= s2 & ~s3;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      if (!enable) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    state_next = ARM;
            ARM:     if (edge_tick) state_next = MEASURE;
            // An edge landing on the overflow cycle immediately re-arms
            MEASURE: if (ovf_hit && !edge_tick) state_next = ARM;
            default: state_next = IDLE;
         endcase
      end
   end

   // Control decode
   always_comb begin
      ovf_hit = enable && (state == MEASURE) && (cnt == CNT_LIMIT);
      take    = enable && (state == MEASURE) && edge_tick && !ovf_hit;
   end

`ifdef TICK_PERIOD_AVERAGING_EN
   logic [WIDTH+2:0] sum;
   logic [WIDTH+2:0] sum_next;
   logic [WIDTH:0]   avg_m1;
   logic [1:0]       grp;
   logic             restart_avg;

   always_comb begin
      sum_next    = sum + {2'b00, cnt};
      avg_m1      = sum_next[WIDTH+2:2] - 1'b1;
      restart_avg = !enable || (state != MEASURE) || ovf_hit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum <= '0;
         grp <= '0;
      end else if (restart_avg) begin
         sum <= '0;
         grp <= '0;
      end else if (take) begin
         grp <= grp + 1'b1;
         sum <= (grp == 2'd3) ? '0 : sum_next;
      end
   end
`endif

   // Counter and measurement outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         divider_out <= '0;
         valid       <= 1'b0;
         locked      <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         valid <= 1'b0;
         // Placed before any set so that a simultaneous set wins
         if (clear) overflow <= 1'b0;
         if (!enable) begin
            cnt    <= '0;
            locked <= 1'b0;
         end else begin
            case (state)
               ARM: cnt <= {{WIDTH{1'b0}}, edge_tick};
               MEASURE: begin
                  if (ovf_hit) begin
                     overflow <= 1'b1;
                     locked   <= 1'b0;
                     cnt      <= {{WIDTH{1'b0}}, edge_tick};
                  end else if (edge_tick) begin
                     cnt <= {{WIDTH{1'b0}}, 1'b1};
`ifdef TICK_PERIOD_AVERAGING_EN
                     if (grp == 2'd3) begin
                        divider_out <= avg_m1[WIDTH-1:0];
                        valid       <= 1'b1;
                        locked      <= 1'b1;
                     end
`else
                     // N = 2**WIDTH wraps to all-ones, which is exactly N-1
                     divider_out <= cnt[WIDTH-1:0] - 1'b1;
                     valid       <= 1'b1;
                     locked      <= 1'b1;
`endif
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: cnt <= '0;
            endcase
         end
      end
   end

   // take is consumed only by the averaging path
   logic unused_take;
   always_comb unused_take = take;

endmodule

// File: tb/tb_tick_period_meter.sv
module tb_tick_period_meter;
   localparam int W = 8;
`ifdef TICK_PERIOD_AVERAGING_EN
   localparam int GRP = 4;
`else
   localparam int GRP = 1;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         enable = 1'b0;
   logic         clear = 1'b0;
   logic         sig_in = 1'b0;
   logic         edge_tick;
   logic         valid;
   logic         locked;
   logic         overflow;
   logic [W-1:0] divider_out;

   int n_pass = 0;
   int n_total = 0;
   int vq[$];
   int edge_cnt = 0;
   int bad_valid = 0;
   logic prev_edge = 1'b0;

   tick_period_meter #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .sig_in(sig_in),
      .edge_tick(edge_tick), .divider_out(divider_out), .valid(valid),
      .locked(locked), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Record every update and check that it follows an edge_tick by one cycle
   always @(negedge clk) begin
      if (valid) begin
         vq.push_back(int'(divider_out));
         if (!prev_edge) bad_valid++;
      end
      if (edge_tick) edge_cnt++;
      prev_edge = edge_tick;
   end

   function automatic void check(string name, int act, int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Rising edge on sig_in now, then idle so the next rise is gap cycles later
   task automatic rise_then(input int gap);
      sig_in = 1'b1;
      tick();
      sig_in = 1'b0;
      repeat (gap - 1) tick();
   endtask

   task automatic restart();
      enable = 1'b0;
      clear  = 1'b1;
      sig_in = 1'b0;
      repeat (6) tick();
      clear  = 1'b0;
      enable = 1'b1;
      repeat (2) tick();
      vq.delete();
   endtask

   typedef struct {
      int gap;
      bit v;
      int dv;
      bit ovf;
      bit lk;
   } vec_t;

   initial begin
      vec_t tbl[8];
      int   rt[8];
      int   gaps[$];
      int   exp_q[$];
      int   m_sum, m_cnt, g, e0;
      bit   m_ovf, m_lk;

      tbl = '{'{0, 0, 0, 0, 0}, '{10, 1, 9, 0, 1}, '{2, 1, 1, 0, 1},
              '{256, 1, 255, 0, 1}, '{257, 0, 255, 1, 0}, '{5, 1, 4, 1, 1},
              '{300, 0, 4, 1, 0}, '{7, 1, 6, 1, 1}};

      // Reset state
      repeat (3) tick();
      check("rst_edge_tick", edge_tick, 0);
      check("rst_valid", valid, 0);
      check("rst_locked", locked, 0);
      check("rst_overflow", overflow, 0);
      check("rst_divider", divider_out, 0);
      rst_n  = 1'b1;
      enable = 1'b1;
      repeat (3) tick();

`ifndef TICK_PERIOD_AVERAGING_EN
      // Table: a rise at iteration r shows up on valid at iteration r+4
      rt[0] = 0;
      for (int i = 1; i < 8; i++) rt[i] = rt[i-1] + tbl[i].gap;
      for (int c = 0; c <= rt[7] + 4; c++) begin
         for (int i = 0; i < 8; i++) begin
            if (c == rt[i] + 4) begin
               check($sformatf("tbl%0d_valid", i), valid, tbl[i].v);
               check($sformatf("tbl%0d_divider", i), divider_out, tbl[i].dv);
               check($sformatf("tbl%0d_overflow", i), overflow, tbl[i].ovf);
               check($sformatf("tbl%0d_locked", i), locked, tbl[i].lk);
            end
         end
         sig_in = 1'b0;
         for (int i = 0; i < 8; i++) if (c == rt[i]) sig_in = 1'b1;
         tick();
      end
      sig_in = 1'b0;
`else
      // Averaging: 10,10,11,11 -> one update of floor(42/4)-1
      restart();
      rise_then(10); rise_then(10); rise_then(11); rise_then(11); rise_then(8);
      check("avg_count", vq.size(), 1);
      if (vq.size() > 0) check("avg_divider", vq[0], 9);
      check("avg_locked", locked, 1);
      // Enable drop mid-block yields no update
      restart();
      rise_then(10); rise_then(10); rise_then(10);
      enable = 1'b0;
      tick(); tick();
      check("avg_drop_count", vq.size(), 0);
      check("avg_drop_locked", locked, 0);
      enable = 1'b1;
`endif

      // Simultaneous overflow set and clear: set wins, clear next cycle
      restart();
      check("clr_ovf_pre", overflow, 0);
      sig_in = 1'b1;
      tick();
      sig_in = 1'b0;
      repeat (259) tick();
      check("clr_ovf_not_yet", overflow, 0);
      clear = 1'b1;
      tick();
      check("clr_set_wins", overflow, 1);
      check("clr_locked", locked, 0);
      tick();
      check("clr_cleared", overflow, 0);
      clear = 1'b0;

      // Async reset mid-interval, then 20-cycle edges
      restart();
      for (int i = 0; i < GRP + 1; i++) rise_then(20);
      rise_then(8);
      #2 rst_n = 1'b0;
      #1;
      check("arst_edge_tick", edge_tick, 0);
      check("arst_valid", valid, 0);
      check("arst_locked", locked, 0);
      check("arst_overflow", overflow, 0);
      check("arst_divider", divider_out, 0);
      tick(); tick();
      rst_n = 1'b1;
      repeat (3) tick();
      vq.delete();
      for (int i = 0; i < GRP + 1; i++) rise_then(20);
      check("arst_count", vq.size(), 1);
      if (vq.size() > 0) check("arst_divider19", vq[0], 19);
      check("arst_relock", locked, 1);

      // Round trip from a divider of 23 (tick every 24 cycles)
      restart();
      for (int i = 0; i < 2 * GRP + 1; i++) rise_then(24);
      check("rt_count", vq.size(), 2);
      foreach (vq[i]) check($sformatf("rt_div%0d", i), vq[i], 23);
      check("rt_locked", locked, 1);

      // Enable drop: locked falls, divider holds, edges still reported
      enable = 1'b0;
      tick(); tick();
      check("dis_locked", locked, 0);
      check("dis_divider", divider_out, 23);
      vq.delete();
      e0 = edge_cnt;
      for (int i = 0; i < 3; i++) rise_then(10);
      check("dis_no_valid", vq.size(), 0);
      check("dis_edge_ticks", edge_cnt - e0, 3);

      // Randomized intervals against an interval-level model
      restart();
      for (int k = 0; k < 40; k++) begin
         g = ($urandom_range(0, 7) == 0) ? int'($urandom_range(250, 265))
                                         : int'($urandom_range(2, 40));
         gaps.push_back(g);
      end
      m_sum = 0; m_cnt = 0; m_ovf = 0; m_lk = 0;
      foreach (gaps[k]) begin
         if (gaps[k] > (1 << W)) begin
            m_ovf = 1; m_lk = 0; m_sum = 0; m_cnt = 0;
         end else begin
            m_sum += gaps[k];
            m_cnt++;
            if (m_cnt == GRP) begin
               exp_q.push_back(m_sum / GRP - 1);
               m_lk = 1; m_sum = 0; m_cnt = 0;
            end
         end
      end
      foreach (gaps[k]) rise_then(gaps[k]);
      rise_then(10);
      check("rnd_count", vq.size(), exp_q.size());
      foreach (exp_q[k]) begin
         if (k < vq.size()) check($sformatf("rnd_div%0d", k), vq[k], exp_q[k]);
      end
      check("rnd_overflow", overflow, m_ovf);
      check("rnd_locked", locked, m_lk);
      check("valid_after_edge", bad_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
